// File: rtl/arbitro_rr_pkg.sv
// Shared definitions for the round-robin FIFO arbiter: state encoding,
// fixed input count and the grant-index width.
package arbitro_rr_pkg;

    localparam int NUM_ENTRADAS = 4;
    localparam int SEL_BITS     = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARBITRA = 2'd1,
        PAUSA   = 2'd2
    } estado_t;

    // Index to one-hot vector over the arbitrated FIFOs.
    function automatic logic [NUM_ENTRADAS-1:0] a_onehot(input logic [SEL_BITS-1:0] idx);
        return {{(NUM_ENTRADAS-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/arbitro_rr_if.sv
// Arbiter-side bundle: FIFO status in, pop/mux/push controls out.
interface arbitro_rr_if;
    import arbitro_rr_pkg::*;

    logic [NUM_ENTRADAS-1:0] vacio;
    logic                    casi_lleno;
    logic [NUM_ENTRADAS-1:0] pop;
    logic [SEL_BITS-1:0]     selector;
    logic                    mux_enb;
    logic                    push;
    logic [NUM_ENTRADAS-1:0] activo;

    // Arbiter view.
    modport master (
        input  vacio, casi_lleno,
        output pop, selector, mux_enb, push, activo
    );

    // FIFO/mux environment view.
    modport slave (
        output vacio, casi_lleno,
        input  pop, selector, mux_enb, push, activo
    );
endinterface

// File: rtl/arbitro_rr_busca.sv
// Round-robin search: first non-empty FIFO starting at ultimo+1, wrapping
// 3->0, with ultimo itself checked last.
module rr_busca
    import arbitro_rr_pkg::*;
(
    input  logic [NUM_ENTRADAS-1:0] vacio,
    input  logic [SEL_BITS-1:0]     ultimo,
    output logic [SEL_BITS-1:0]     idx,
    output logic                    hay_dato
);

    logic [SEL_BITS-1:0] cand;

    // Walk candidates from farthest to nearest so the nearest hit wins.
    always_comb begin
        idx      = '0;
        hay_dato = 1'b0;
        cand     = '0;
        for (int i = NUM_ENTRADAS; i >= 1; i--) begin
            cand = ultimo + SEL_BITS'(i);
            if (!vacio[cand]) begin
                idx      = cand;
                hay_dato = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbitro_rr.sv
// Round-robin arbiter in front of the 4:1 mux. Pops the granted input FIFO
// for up to BURST words, then rotates. The mux select/enable and the output
// FIFO push follow each pop by one cycle, matching the registered FIFO dout.
module arbitro_rr
    import arbitro_rr_pkg::*;
#(
    parameter int BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    arbitro_rr_if.master  bus
);

    localparam logic [3:0] BURST_L = 4'(BURST);

    estado_t                 estado;
    logic [SEL_BITS-1:0]     grant;
    logic [SEL_BITS-1:0]     ultimo;
    logic [3:0]              cnt;
    logic [SEL_BITS-1:0]     selector_q;
    logic                    mux_enb_q;
    logic                    push_q;
    logic [NUM_ENTRADAS-1:0] activo_q;

    logic [SEL_BITS-1:0]     base;
    logic [SEL_BITS-1:0]     sig;
    logic                    hay;
    logic                    hace_pop;
    logic                    fin_rafaga;
    logic [NUM_ENTRADAS-1:0] pop_w;

    // From IDLE the search resumes after the last owner; while granted it
    // starts after the current owner, which is where a rotation goes next.
    assign base = (estado == IDLE) ? ultimo : grant;

    rr_busca u_busca (
        .vacio    (bus.vacio),
        .ultimo   (base),
        .idx      (sig),
        .hay_dato (hay)
    );

    // casi_lleno and reset both override an otherwise legal pop.
    assign hace_pop   = !reset && (estado == ARBITRA) && !bus.vacio[grant] && !bus.casi_lleno;
    assign fin_rafaga = (cnt + 4'd1) == BURST_L;

    // One-hot pop to the granted FIFO.
    always_comb begin
        pop_w = '0;
        if (hace_pop) pop_w[grant] = 1'b1;
    end

    // Grant FSM, burst counter and the delayed mux/push controls.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado     <= IDLE;
            grant      <= '0;
            ultimo     <= SEL_BITS'(NUM_ENTRADAS - 1);
            cnt        <= '0;
            selector_q <= '0;
            mux_enb_q  <= 1'b0;
            push_q     <= 1'b0;
            activo_q   <= '0;
        end else begin
            mux_enb_q <= hace_pop;
            push_q    <= hace_pop;
            if (hace_pop) selector_q <= grant;

            case (estado)
                IDLE: begin
                    if (!bus.casi_lleno && hay) begin
                        grant    <= sig;
                        cnt      <= '0;
                        activo_q <= a_onehot(sig);
                        estado   <= ARBITRA;
                    end
                end
                ARBITRA: begin
                    if (bus.casi_lleno) begin
                        estado <= PAUSA;
                    end else if (hace_pop && !fin_rafaga) begin
                        cnt <= cnt + 4'd1;
                    end else begin
                        // Burst done or owner ran dry: hand over. A lone
                        // non-empty FIFO is found again with no bubble.
                        ultimo <= grant;
                        cnt    <= '0;
                        if (hay) begin
                            grant    <= sig;
                            activo_q <= a_onehot(sig);
                        end else begin
                            activo_q <= '0;
                            estado   <= IDLE;
                        end
                    end
                end
                PAUSA: begin
                    if (!bus.casi_lleno) estado <= ARBITRA;
                end
                default: estado <= IDLE;
            endcase
        end
    end

    assign bus.pop      = pop_w;
    assign bus.selector = selector_q;
    assign bus.mux_enb  = mux_enb_q;
    assign bus.push     = push_q;
    assign bus.activo   = activo_q;

endmodule

// File: tb/tb_arbitro_rr.sv
// Directed bench for arbitro_rr: FIFO occupancies drive vacio, each cycle's
// pop is compared with a hand-written sequence, and the following cycle's
// push/mux_enb/selector are checked against that same sequence.
module tb_arbitro_rr;
    import arbitro_rr_pkg::*;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    int   cuentas[4];
    logic casi;

    arbitro_rr_if bus ();

    arbitro_rr #(.BURST(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] idx_de(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
        return r;
    endfunction

    // One cycle, entered and left at negedge: apply inputs, sample pop,
    // consume popped words at the edge.
    task automatic paso(output logic [3:0] p);
        for (int i = 0; i < 4; i++) bus.vacio[i] = (cuentas[i] == 0);
        bus.casi_lleno = casi;
        #1;
        p = bus.pop;
        @(posedge clk);
        for (int i = 0; i < 4; i++) if (p[i] && cuentas[i] > 0) cuentas[i]--;
        @(negedge clk);
    endtask

    // One cycle with the expected pop; registered outputs must echo it.
    task automatic corre(input string t, input logic [3:0] exp);
        logic [3:0] p;
        paso(p);
        chk({t, " pop"}, 32'(p), 32'(exp));
        chk({t, " push"}, 32'(bus.push), 32'(exp != 4'b0));
        chk({t, " mux_enb"}, 32'(bus.mux_enb), 32'(exp != 4'b0));
        if (exp != 4'b0) chk({t, " sel"}, 32'(bus.selector), 32'(idx_de(exp)));
    endtask

    task automatic rst_seq;
        reset = 1'b1;
        casi  = 1'b0;
        for (int i = 0; i < 4; i++) cuentas[i] = 0;
        bus.vacio      = 4'hF;
        bus.casi_lleno = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] p;
        logic [3:0] e4[10];
        logic       c4[10];
        n_cmp = 0;
        n_err = 0;

        // 1: reset values, then idle with everything empty
        reset          = 1'b1;
        casi           = 1'b0;
        bus.vacio      = 4'hF;
        bus.casi_lleno = 1'b0;
        @(negedge clk);
        chk("t1 pop in reset", 32'(bus.pop), 32'h0);
        rst_seq();
        chk("t1 sel rst", 32'(bus.selector), 32'h0);
        chk("t1 push rst", 32'(bus.push), 32'h0);
        chk("t1 activo rst", 32'(bus.activo), 32'h0);
        for (int k = 0; k < 10; k++) begin
            corre("t1", 4'b0000);
            chk("t1 sel", 32'(bus.selector), 32'h0);
            chk("t1 activo", 32'(bus.activo), 32'h0);
        end

        // 2: lone FIFO 2 with 6 words, re-granted across the burst boundary
        rst_seq();
        cuentas[2] = 6;
        corre("t2", 4'b0000);
        chk("t2 activo", 32'(bus.activo), 32'h4);
        for (int k = 0; k < 6; k++) corre("t2", 4'b0100);
        corre("t2 tail", 4'b0000);
        chk("t2 activo idle", 32'(bus.activo), 32'h0);

        // 3: all deep -> 0,1,2,3,0 in bursts of 4 with no gaps
        rst_seq();
        for (int i = 0; i < 4; i++) cuentas[i] = 20;
        corre("t3", 4'b0000);
        for (int k = 0; k < 20; k++) corre("t3", 4'(1 << ((k / 4) % 4)));

        // 4: almost-full for 3 cycles after 2 pops from FIFO 1
        rst_seq();
        cuentas[1] = 10;
        cuentas[2] = 10;
        e4 = '{4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h4};
        c4 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 10; k++) begin
            casi = c4[k];
            corre("t4", e4[k]);
            if (k == 5) chk("t4 activo pausa", 32'(bus.activo), 32'h2);
        end
        casi = 1'b0;

        // 5: FIFO 3 drains after one pop, FIFO 0 fills -> wrap to 0
        rst_seq();
        cuentas[3] = 1;
        corre("t5", 4'b0000);
        corre("t5", 4'b1000);
        cuentas[0] = 5;
        corre("t5 rot", 4'b0000);
        chk("t5 activo", 32'(bus.activo), 32'h1);
        corre("t5", 4'b0001);

        // 6: reset mid-burst, restart from the lowest non-empty FIFO
        rst_seq();
        for (int i = 0; i < 4; i++) cuentas[i] = 10;
        corre("t6", 4'b0000);
        corre("t6", 4'b0001);
        corre("t6", 4'b0001);
        reset = 1'b1;
        #1;
        chk("t6 pop gated", 32'(bus.pop), 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("t6 push", 32'(bus.push), 32'h0);
        chk("t6 mux_enb", 32'(bus.mux_enb), 32'h0);
        chk("t6 sel", 32'(bus.selector), 32'h0);
        chk("t6 activo", 32'(bus.activo), 32'h0);
        cuentas[0] = 0;
        reset = 1'b0;
        corre("t6 post", 4'b0000);
        corre("t6 post", 4'b0010);
        paso(p);
        chk("t6 post pop", 32'(p), 32'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
